chimp_board_loader: RTL

- Sequencer that builds a new Chimp board before each round: clears the tile memory, then places tiles numbered 1..level at distinct pseudo-random grid cells.
- Sits between the Chimp control path and the tile RAM read by the renderer and press decoder.
- The control path pulses iStart with the current level and waits for oDone before showing the board.

---
 rtl/chimp_board_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/chimp_board_loader.sv
// Builds a Chimp board: clears every cell, then places tiles 1..level in distinct LFSR-chosen cells.
// Writes are registered and held until iWrReady, with an idle gap after each one. CHIMP_LOADER_SEED_EN adds iSeed.
module chimp_board_loader #(
   parameter int          CELLS  = 40,
   parameter int          ADDR_W = 6,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic              clk,
   input  logic              iReset,
   input  logic              iStart,
   input  logic [4:0]        iLevel,
   input  logic              iAbort,
   input  logic              iWrReady,
`ifdef CHIMP_LOADER_SEED_EN
   input  logic [15:0]       iSeed,
`endif
   output logic              oWrEn,
   output logic [ADDR_W-1:0] oWrAddr,
   output logic [4:0]        oWrData,
   output logic              oBusy,
   output logic              oDone,
   output logic [4:0]        oPlaced
);

   localparam int                OCC_N = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;

   state_t            state_q, state_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [4:0]        lvl_q, lvl_d;
   logic [OCC_N-1:0]  occ_q, occ_d;
   logic [ADDR_W-1:0] clr_q, clr_d;
   logic              wr_en_d, busy_d, done_d;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [4:0]        wr_data_d, placed_d;
   logic [ADDR_W-1:0] cand;
   logic              cand_ok, wr_done, abort;

   assign cand    = lfsr_q[ADDR_W-1:0];
   assign cand_ok = (cand <= LAST) && !occ_q[cand];
   assign wr_done = oWrEn && iWrReady;
   assign abort   = iAbort && (state_q != IDLE);

   always_ff @(posedge clk or posedge iReset) begin
      if (iReset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (iStart) state_d = CLEAR;
         CLEAR: if (abort) state_d = IDLE;
                else if (wr_done && oWrAddr == LAST) state_d = (lvl_q != 5'd0) ? PLACE : DONE;
         PLACE: if (abort) state_d = IDLE;
                else if (wr_done && (oPlaced + 5'd1) == lvl_q) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      lvl_d     = lvl_q;
      occ_d     = occ_q;
      clr_d     = clr_q;
      wr_en_d   = oWrEn;
      wr_addr_d = oWrAddr;
      wr_data_d = oWrData;
      placed_d  = oPlaced;
      case (state_q)
         IDLE: if (iStart) begin
            lvl_d    = iLevel;
            occ_d    = '0;
            clr_d    = '0;
            placed_d = 5'd0;
`ifdef CHIMP_LOADER_SEED_EN
            lfsr_d   = (iSeed == 16'h0000) ? SEED : iSeed;
`endif
         end
         CLEAR: if (wr_done) begin
            wr_en_d = 1'b0;
            clr_d   = clr_q + ADDR_W'(1);
         end else if (!oWrEn) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_q;
            wr_data_d = 5'd0;
         end
         PLACE: if (wr_done) begin
            wr_en_d  = 1'b0;
            placed_d = oPlaced + 5'd1;
         end else if (!oWrEn && cand_ok) begin
            // Occupancy is marked at accept time so a stalled write cannot be re-picked.
            wr_en_d     = 1'b1;
            wr_addr_d   = cand;
            wr_data_d   = oPlaced + 5'd1;
            occ_d[cand] = 1'b1;
         end
         default: ;
      endcase
      if (abort) wr_en_d = 1'b0;
      busy_d = (state_d == CLEAR) || (state_d == PLACE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge iReset) begin
      if (iReset) begin
         lfsr_q  <= SEED;
         lvl_q   <= 5'd0;
         occ_q   <= '0;
         clr_q   <= '0;
         oWrEn   <= 1'b0;
         oWrAddr <= '0;
         oWrData <= 5'd0;
         oBusy   <= 1'b0;
         oDone   <= 1'b0;
         oPlaced <= 5'd0;
      end else begin
         lfsr_q  <= lfsr_d;
         lvl_q   <= lvl_d;
         occ_q   <= occ_d;
         clr_q   <= clr_d;
         oWrEn   <= wr_en_d;
         oWrAddr <= wr_addr_d;
         oWrData <= wr_data_d;
         oBusy   <= busy_d;
         oDone   <= done_d;
         oPlaced <= placed_d;
      end
   end

endmodule
